// File: rtl/dec_exu_pipe_fifo_pkg.sv
// Shared payload layout for the decode->execute buffer and small sizing helpers.
// The instantiator packs dec2ex_t into the opaque DW-bit payload and unpacks it again.
package dec_exu_pipe_fifo_pkg;

    localparam int MYRISCV_ADDRBUS    = 32;
    localparam int REGBUS             = 32;
    localparam int REGADDRBUS         = 5;
    localparam int E203_DECINFO_WIDTH = 32;

    typedef struct packed {
        logic [MYRISCV_ADDRBUS-1:0]    pc;
        logic [REGBUS-1:0]             rs1_val;
        logic [REGBUS-1:0]             rs2_val;
        logic [REGADDRBUS-1:0]         rs1_idx;
        logic [REGADDRBUS-1:0]         rs2_idx;
        logic [REGBUS-1:0]             imm;
        logic                          rd_wen;
        logic [REGADDRBUS-1:0]         rd_idx;
        logic [E203_DECINFO_WIDTH-1:0] info;
    } dec2ex_t;

    localparam int DEC2EX_W = $bits(dec2ex_t);

    // Pointer width; a single-entry buffer still carries a 1-bit pointer.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dec_exu_pipe_mem.sv
// DEPTH x DW register array: one write port, one asynchronous read port, cleared on reset.
module dec_exu_pipe_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    parameter int PW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [PW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr_i == PW'(i)) mem_q[i] <= wdata_i;
            end
        end
    end

    // Decoded read keeps out-of-range addresses harmless for non-power-of-two DEPTH.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_i == PW'(i)) rdata_o = mem_q[i];
        end
    end

endmodule

// File: rtl/dec_exu_pipe_fifo.sv
// Flushable in-order valid/ready buffer between decode and execute, fully registered output.
// On flush it can keep a head entry that execute is still stalled on.
module dec_exu_pipe_fifo
    import dec_exu_pipe_fifo_pkg::*;
#(
    parameter  int DW        = 32,
    parameter  int DEPTH     = 2,
    parameter  int KEEP_HEAD = 1,
    parameter  int PASS_RDY  = 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          s_vld_i,
    output logic          s_rdy_o,
    input  logic [DW-1:0] s_data_i,
    output logic          m_vld_o,
    input  logic          m_rdy_i,
    output logic [DW-1:0] m_data_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign m_vld_o = (count_q != '0);
    assign count_o = count_q;
    assign s_rdy_o = (count_q != CW'(DEPTH)) | ((PASS_RDY != 0) & m_rdy_i);
    assign pop     = m_vld_o & m_rdy_i;
    assign push    = s_vld_i & s_rdy_o & ~flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            if ((KEEP_HEAD != 0) && m_vld_o && !m_rdy_i) begin
                wr_ptr_d = ptr_inc(rd_ptr_q);
                count_d  = CW'(1);
            end else begin
                // A head taken in the flush cycle still counts as delivered.
                rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
                wr_ptr_d = rd_ptr_d;
                count_d  = '0;
            end
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    dec_exu_pipe_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (s_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (m_data_o)
    );

endmodule

// File: tb/tb_dec_exu_pipe_fifo.sv
// Directed bench for dec_exu_pipe_fifo over four parameterisations sharing clk/rst.
module tb_dec_exu_pipe_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // A: DEPTH=3, KEEP_HEAD=1, PASS_RDY=0
    logic       a_flush = 0, a_s_vld = 0, a_m_rdy = 0, a_s_rdy, a_m_vld;
    logic [7:0] a_s_data = 0, a_m_data;
    logic [1:0] a_count;
    // B: DEPTH=2, KEEP_HEAD=1, PASS_RDY=0
    logic       b_flush = 0, b_s_vld = 0, b_m_rdy = 0, b_s_rdy, b_m_vld;
    logic [7:0] b_s_data = 0, b_m_data;
    logic [1:0] b_count;
    // C: DEPTH=3, KEEP_HEAD=0, PASS_RDY=0
    logic       c_flush = 0, c_s_vld = 0, c_m_rdy = 0, c_s_rdy, c_m_vld;
    logic [7:0] c_s_data = 0, c_m_data;
    logic [1:0] c_count;
    // D: DEPTH=1, KEEP_HEAD=1, PASS_RDY=1
    logic       d_flush = 0, d_s_vld = 0, d_m_rdy = 0, d_s_rdy, d_m_vld;
    logic [7:0] d_s_data = 0, d_m_data;
    logic [0:0] d_count;

    dec_exu_pipe_fifo #(.DW(8), .DEPTH(3), .KEEP_HEAD(1), .PASS_RDY(0)) u_a (
        .clk(clk), .rst(rst), .flush_i(a_flush), .s_vld_i(a_s_vld), .s_rdy_o(a_s_rdy),
        .s_data_i(a_s_data), .m_vld_o(a_m_vld), .m_rdy_i(a_m_rdy), .m_data_o(a_m_data),
        .count_o(a_count));
    dec_exu_pipe_fifo #(.DW(8), .DEPTH(2), .KEEP_HEAD(1), .PASS_RDY(0)) u_b (
        .clk(clk), .rst(rst), .flush_i(b_flush), .s_vld_i(b_s_vld), .s_rdy_o(b_s_rdy),
        .s_data_i(b_s_data), .m_vld_o(b_m_vld), .m_rdy_i(b_m_rdy), .m_data_o(b_m_data),
        .count_o(b_count));
    dec_exu_pipe_fifo #(.DW(8), .DEPTH(3), .KEEP_HEAD(0), .PASS_RDY(0)) u_c (
        .clk(clk), .rst(rst), .flush_i(c_flush), .s_vld_i(c_s_vld), .s_rdy_o(c_s_rdy),
        .s_data_i(c_s_data), .m_vld_o(c_m_vld), .m_rdy_i(c_m_rdy), .m_data_o(c_m_data),
        .count_o(c_count));
    dec_exu_pipe_fifo #(.DW(8), .DEPTH(1), .KEEP_HEAD(1), .PASS_RDY(1)) u_d (
        .clk(clk), .rst(rst), .flush_i(d_flush), .s_vld_i(d_s_vld), .s_rdy_o(d_s_rdy),
        .s_data_i(d_s_data), .m_vld_o(d_m_vld), .m_rdy_i(d_m_rdy), .m_data_o(d_m_data),
        .count_o(d_count));

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_run++; if (a_m_vld !== 1'b0) begin n_fail++; $display("FAIL reset_a_m_vld got %b exp 0", a_m_vld); end
        n_run++; if (a_s_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_a_s_rdy got %b exp 1", a_s_rdy); end
        n_run++; if (a_count !== 2'd0) begin n_fail++; $display("FAIL reset_a_count got %0d exp 0", a_count); end
        n_run++; if (a_m_data !== 8'h00) begin n_fail++; $display("FAIL reset_a_m_data got %h exp 00", a_m_data); end
        n_run++; if (d_m_vld !== 1'b0 || d_s_rdy !== 1'b1 || d_count !== 1'd0)
            begin n_fail++; $display("FAIL reset_d got vld=%b rdy=%b cnt=%0d exp 0 1 0", d_m_vld, d_s_rdy, d_count); end
    endtask

    task automatic test_fill_wrap;
        logic [7:0] exp_d;
        a_m_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_run++; if (a_s_rdy !== (i < 3)) begin n_fail++; $display("FAIL fill_s_rdy[%0d] got %b exp %b", i, a_s_rdy, (i < 3)); end
            a_s_vld = 1'b1; a_s_data = 8'(8'hA1 + i);
        end
        @(negedge clk);
        a_s_vld = 1'b0;
        n_run++; if (a_count !== 2'd3) begin n_fail++; $display("FAIL full_count got %0d exp 3", a_count); end
        n_run++; if (a_s_rdy !== 1'b0) begin n_fail++; $display("FAIL full_s_rdy got %b exp 0", a_s_rdy); end
        a_m_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_d = 8'(8'hA1 + i);
            n_run++; if (a_m_vld !== 1'b1 || a_m_data !== exp_d)
                begin n_fail++; $display("FAIL drain[%0d] got vld=%b data=%h exp 1 %h", i, a_m_vld, a_m_data, exp_d); end
            @(negedge clk);
        end
        n_run++; if (a_m_vld !== 1'b0 || a_count !== 2'd0)
            begin n_fail++; $display("FAIL drain_empty got vld=%b cnt=%0d exp 0 0", a_m_vld, a_count); end
        // Stream across the wrap with latency 1.
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin
                exp_d = 8'(8'hC0 + k - 1);
                n_run++; if (a_m_vld !== 1'b1 || a_m_data !== exp_d || a_count !== 2'd1)
                    begin n_fail++; $display("FAIL wrap_stream[%0d] got vld=%b data=%h cnt=%0d exp 1 %h 1", k, a_m_vld, a_m_data, a_count, exp_d); end
            end
            a_s_vld = (k < 5); a_s_data = 8'(8'hC0 + k);
            @(negedge clk);
        end
        n_run++; if (a_m_vld !== 1'b0 || a_count !== 2'd0)
            begin n_fail++; $display("FAIL wrap_empty got vld=%b cnt=%0d exp 0 0", a_m_vld, a_count); end
        a_m_rdy = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_d;
        @(negedge clk);
        b_m_rdy = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                exp_d = 8'(8'h50 + k - 1);
                n_run++; if (b_m_vld !== 1'b1 || b_m_data !== exp_d || b_count !== 2'd1 || b_s_rdy !== 1'b1)
                    begin n_fail++; $display("FAIL b2b[%0d] got vld=%b data=%h cnt=%0d rdy=%b exp 1 %h 1 1", k, b_m_vld, b_m_data, b_count, b_s_rdy, exp_d); end
            end
            b_s_vld = (k < 10); b_s_data = 8'(8'h50 + k);
            @(negedge clk);
        end
        n_run++; if (b_m_vld !== 1'b0 || b_count !== 2'd0)
            begin n_fail++; $display("FAIL b2b_empty got vld=%b cnt=%0d exp 0 0", b_m_vld, b_count); end
        b_m_rdy = 1'b0;
    endtask

    task automatic test_flush_keep;
        a_m_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_s_vld = 1'b1; a_s_data = 8'(8'h10 * (i + 1));
        end
        @(negedge clk);
        n_run++; if (a_count !== 2'd3 || a_m_data !== 8'h10)
            begin n_fail++; $display("FAIL keep_setup got cnt=%0d data=%h exp 3 10", a_count, a_m_data); end
        a_flush = 1'b1; a_s_vld = 1'b1; a_s_data = 8'h40;
        @(negedge clk);
        a_flush = 1'b0; a_s_vld = 1'b0;
        n_run++; if (a_count !== 2'd1 || a_m_vld !== 1'b1 || a_m_data !== 8'h10)
            begin n_fail++; $display("FAIL keep_head got cnt=%0d vld=%b data=%h exp 1 1 10", a_count, a_m_vld, a_m_data); end
        n_run++; if (a_s_rdy !== 1'b1) begin n_fail++; $display("FAIL keep_s_rdy got %b exp 1", a_s_rdy); end
        a_m_rdy = 1'b1;
        @(negedge clk);
        n_run++; if (a_count !== 2'd0 || a_m_vld !== 1'b0)
            begin n_fail++; $display("FAIL keep_drop40 got cnt=%0d vld=%b exp 0 0", a_count, a_m_vld); end
        a_m_rdy = 1'b0;
    endtask

    task automatic test_flush_deliver;
        for (int i = 0; i < 3; i++) begin
            a_s_vld = 1'b1; a_s_data = 8'(8'h10 * (i + 1));
            @(negedge clk);
        end
        a_s_vld = 1'b0;
        a_flush = 1'b1; a_m_rdy = 1'b1;
        n_run++; if (a_m_vld !== 1'b1 || a_m_data !== 8'h10)
            begin n_fail++; $display("FAIL deliver_head got vld=%b data=%h exp 1 10", a_m_vld, a_m_data); end
        @(negedge clk);
        a_flush = 1'b0; a_m_rdy = 1'b0;
        n_run++; if (a_count !== 2'd0 || a_m_vld !== 1'b0)
            begin n_fail++; $display("FAIL deliver_empty got cnt=%0d vld=%b exp 0 0", a_count, a_m_vld); end
        a_s_vld = 1'b1; a_s_data = 8'h55;
        @(negedge clk);
        a_s_vld = 1'b0;
        n_run++; if (a_count !== 2'd1 || a_m_data !== 8'h55)
            begin n_fail++; $display("FAIL deliver_refill got cnt=%0d data=%h exp 1 55", a_count, a_m_data); end
        a_m_rdy = 1'b1;
        @(negedge clk);
        a_m_rdy = 1'b0;
    endtask

    task automatic test_flush_drop;
        c_m_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            c_s_vld = 1'b1; c_s_data = 8'(8'h10 * (i + 1));
        end
        @(negedge clk);
        n_run++; if (c_s_rdy !== 1'b1 || c_count !== 2'd2)
            begin n_fail++; $display("FAIL drop_setup got rdy=%b cnt=%0d exp 1 2", c_s_rdy, c_count); end
        c_flush = 1'b1; c_s_vld = 1'b1; c_s_data = 8'h40;
        @(negedge clk);
        c_s_vld = 1'b0;
        n_run++; if (c_count !== 2'd0 || c_m_vld !== 1'b0)
            begin n_fail++; $display("FAIL drop_all got cnt=%0d vld=%b exp 0 0", c_count, c_m_vld); end
        @(negedge clk);
        c_flush = 1'b0;
        n_run++; if (c_count !== 2'd0) begin n_fail++; $display("FAIL flush_empty got cnt=%0d exp 0", c_count); end
        c_s_vld = 1'b1; c_s_data = 8'h66;
        @(negedge clk);
        c_s_vld = 1'b0;
        n_run++; if (c_count !== 2'd1 || c_m_data !== 8'h66)
            begin n_fail++; $display("FAIL drop_refill got cnt=%0d data=%h exp 1 66", c_count, c_m_data); end
        c_m_rdy = 1'b1;
        @(negedge clk);
        c_m_rdy = 1'b0;
    endtask

    task automatic test_pass_rdy;
        logic [7:0] exp_d;
        @(negedge clk);
        d_s_vld = 1'b1; d_s_data = 8'hD0; d_m_rdy = 1'b0;
        @(negedge clk);
        n_run++; if (d_count !== 1'd1 || d_s_rdy !== 1'b0 || d_m_data !== 8'hD0)
            begin n_fail++; $display("FAIL d1_full got cnt=%0d rdy=%b data=%h exp 1 0 d0", d_count, d_s_rdy, d_m_data); end
        d_m_rdy = 1'b1; d_s_data = 8'hD1;
        #1;
        n_run++; if (d_s_rdy !== 1'b1) begin n_fail++; $display("FAIL d1_pass_rdy got %b exp 1", d_s_rdy); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_d = 8'(8'hD0 + k);
            n_run++; if (d_m_vld !== 1'b1 || d_m_data !== exp_d || d_count !== 1'd1 || d_s_rdy !== 1'b1)
                begin n_fail++; $display("FAIL d1_stream[%0d] got vld=%b data=%h cnt=%0d rdy=%b exp 1 %h 1 1", k, d_m_vld, d_m_data, d_count, d_s_rdy, exp_d); end
            d_s_data = 8'(8'hD0 + k + 1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_run++; if (d_count !== 1'd0 || d_m_vld !== 1'b0 || d_m_data !== 8'h00)
            begin n_fail++; $display("FAIL d1_midreset got cnt=%0d vld=%b data=%h exp 0 0 00", d_count, d_m_vld, d_m_data); end
        d_s_vld = 1'b0; d_m_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_wrap();
        test_back_to_back();
        test_flush_keep();
        test_flush_deliver();
        test_flush_drop();
        test_pass_rdy();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_exu_pipe_fifo.md
# dec_exu_pipe_fifo

Parametrised, flushable valid/ready pipeline buffer between decode and execute; generalises the single-entry decode/execute register into a DEPTH-entry in-order queue carrying an opaque DW-bit payload (pc, rs1/rs2 values and indices, imm, rd write-enable/index, decode info are packed by the instantiator). It supports a jump/flush input that discards queued instructions but, in KEEP_HEAD mode, preserves a head entry already stalled in execute, such as a long instruction waiting in the OITF. Output is fully registered: there is no combinational path from s_vld_i/s_data_i to m_vld_o/m_data_o.

## Interface
- DW, 32: payload width in bits (>=1).
- DEPTH, 2: number of entries (>=1, any integer).
- KEEP_HEAD, 1: 1 = flush keeps a head entry that is valid and stalled; 0 = flush drops everything.
- PASS_RDY, 1: 1 = s_rdy_o also asserts when full and m_rdy_i=1 (combinational m_rdy_i->s_rdy_o path); 0 = s_rdy_o depends on state only.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush_i  in  1  jump/flush request from the branch/trap unit.
- s_vld_i  in  1  upstream (decode) valid.
- s_rdy_o  out  1  upstream ready.
- s_data_i  in  DW  upstream payload.
- m_vld_o  out  1  downstream (exu) valid.
- m_rdy_i  in  1  downstream ready.
- m_data_o  out  DW  head payload.
- count_o  out  CW=$clog2(DEPTH+1)  current occupancy.

## Operation
- State: storage[DEPTH], rd_ptr, wr_ptr (range 0..DEPTH-1, explicit wrap DEPTH-1 -> 0), count (0..DEPTH).
- m_vld_o = (count != 0). m_data_o = storage[rd_ptr]. count_o = count.
- s_rdy_o = (count != DEPTH) | (PASS_RDY & m_rdy_i). It does not depend on flush_i.
- pop = m_vld_o & m_rdy_i. push = s_vld_i & s_rdy_o & ~flush_i. During a flush cycle, input is not written, even if the handshake completes.
- Normal cycle (flush_i=0):
  - push writes storage[wr_ptr] and advances wr_ptr.
  - pop advances rd_ptr.
  - count += push - pop.
  - Push and pop in the same cycle while full is legal only when PASS_RDY=1; count is unchanged.
- Flush cycle (flush_i=1):
  - If KEEP_HEAD=1 & m_vld_o & ~m_rdy_i: rd_ptr holds, wr_ptr <= rd_ptr+1 (wrapped), count <= 1. The head payload is unchanged.
  - Otherwise: rd_ptr <= rd_ptr + pop (wrapped), wr_ptr <= that same value, count <= 0. A head consumed in the flush cycle counts as delivered.
- Ordering is strict FIFO. There is no bypass, so an empty-buffer push is visible on m_vld_o in the next cycle.

## Timing
- Reset (rst=1 at an edge):
  - rd_ptr, wr_ptr and count go to 0, and all storage is cleared to 0.
  - Next cycle: m_vld_o=0, m_data_o=0, count_o=0, s_rdy_o=1.
  - Reset takes priority over flush_i and any handshake, and aborts any in-flight push or pop.
- Latency: a push at edge N appears on m_vld_o/m_data_o after edge N, so the minimum latency is 1 cycle.
- Throughput:
  - DEPTH>=2: 1 transfer per cycle sustained regardless of PASS_RDY.
  - DEPTH=1: 1 per cycle only with PASS_RDY=1, which is behaviourally equivalent to the existing single-entry register with flush and keep-head. With PASS_RDY=0 it is 1 per 2 cycles.
- Stability: while m_vld_o=1 & m_rdy_i=0, m_data_o must remain stable. Flush with KEEP_HEAD=1 does not violate this.
- Boundaries:
  - Full with PASS_RDY=0: s_rdy_o=0.
  - Empty: m_vld_o=0 and m_data_o shows the stale storage[rd_ptr]; downstream ignores it.
  - Pointer wrap at DEPTH-1 for non-power-of-two DEPTH (e.g. 3) must be exact.
  - Flush on an empty buffer: count stays 0.
  - Flush with s_vld_i=1 & s_rdy_o=1: the input is dropped, and the upstream must consider it consumed.

## Structure
- Shared defines header: payload field widths and offsets (MYRISCV_ADDRBUS, REGBUS, REGADDRBUS, E203_DECINFO_WIDTH) and a macro for the packed dec2ex payload width. The instantiator packs and unpacks.
- One natural sub-module, dec_exu_pipe_mem: DEPTH x DW register array with synchronous clear on rst, one write port and one asynchronous read port.
- Pointer wrap, count and flush logic stay in the top.

## Test plan
- Reset then idle: rst=1 for 2 cycles -> m_vld_o=0, s_rdy_o=1, count_o=0, m_data_o=0.
- DEPTH=3, m_rdy_i=0, push 0xA1,0xA2,0xA3,0xA4 -> s_rdy_o=0 after 3 pushes (PASS_RDY=0), count_o=3. Then m_rdy_i=1 -> output order A1,A2,A3, and a refill crosses the pointer wrap correctly.
- DEPTH=2, continuous s_vld_i and m_rdy_i=1, 10 words -> one output per cycle, latency 1, no bubbles.
- KEEP_HEAD=1, entries {0x10,0x20,0x30}, m_rdy_i=0, flush_i=1 with s_vld_i=1 data 0x40 -> next cycle count_o=1, m_data_o=0x10; 0x40 is not stored.
- Same setup but m_rdy_i=1 in the flush cycle -> 0x10 is delivered and count_o=0 next cycle. With KEEP_HEAD=0 and m_rdy_i=0 -> count_o=0.
- DEPTH=1, PASS_RDY=1, full, m_rdy_i=1 and s_vld_i=1 -> s_rdy_o=1 and sustained 1/cycle. Assert rst mid-stream -> empty next cycle.
